// File: rtl/accel_req_buffer.sv
// accel_req_buffer: elastic request FIFO between a dispatcher and Ara with an outstanding-instruction limiter.
// Optional perf counters enabled by defining ACCEL_REQ_BUF_PERF_EN.
package accel_req_buffer_pkg;
   typedef struct packed {
      logic        req_valid;
      logic        resp_ready;
      logic [31:0] insn;
      logic [63:0] rs1;
      logic [63:0] rs2;
      logic [2:0]  frm;
   } accelerator_req_t;
   typedef struct packed {
      logic        req_ready;
      logic        resp_valid;
      logic [63:0] result;
      logic        error;
   } accelerator_resp_t;
endpackage

module accel_req_buffer
   import accel_req_buffer_pkg::*;
#(
   parameter int DEPTH           = 4,
   parameter int MAX_OUTSTANDING = 8
) (
   input  logic                                   clk_i,
   input  logic                                   rst_i,
   input  accelerator_req_t                       acc_req_i,
   output accelerator_resp_t                      acc_resp_o,
   output accelerator_req_t                       acc_req_o,
   input  accelerator_resp_t                      acc_resp_i,
   output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o,
   output logic                                   idle_o,
   output logic                                   error_o,
   output logic [31:0]                            perf_issued_o,
   output logic [31:0]                            perf_stall_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int OW = $clog2(MAX_OUTSTANDING + 1);

   accelerator_req_t r_mem [DEPTH];
   logic [AW-1:0]    r_wptr, r_rptr;
   logic [CW-1:0]    r_count;
   logic [OW-1:0]    r_out;
   logic             r_err;
   logic             w_full, w_empty, w_ready, w_valid, w_push, w_pop, w_resp;
   accelerator_req_t w_wdata;

   assign w_full  = r_count == CW'(DEPTH);
   assign w_empty = r_count == '0;
   assign w_ready = !w_full && !rst_i;
   assign w_valid = !w_empty && (r_out < OW'(MAX_OUTSTANDING)) && !rst_i;
   assign w_push  = acc_req_i.req_valid && w_ready;
   assign w_pop   = w_valid && acc_resp_i.req_ready;
   assign w_resp  = acc_resp_i.resp_valid && acc_req_i.resp_ready;

   always_comb begin
      w_wdata                = acc_req_i;
      w_wdata.req_valid      = 1'b0;
      w_wdata.resp_ready     = 1'b0;
      acc_req_o              = r_mem[r_rptr];
      acc_req_o.req_valid    = w_valid;
      acc_req_o.resp_ready   = acc_req_i.resp_ready;
      acc_resp_o             = acc_resp_i;
      acc_resp_o.req_ready   = w_ready;
   end

   always_ff @(posedge clk_i)
      if (w_push) r_mem[r_wptr] <= w_wdata;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         r_out   <= '0;
         r_err   <= 1'b0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop) r_rptr <= r_rptr + 1'b1;
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
         // a response with nothing outstanding is a protocol error, not an underflow
         if (w_pop && !w_resp) r_out <= r_out + 1'b1;
         else if (w_resp && !w_pop) begin
            if (r_out == '0) r_err <= 1'b1;
            else r_out <= r_out - 1'b1;
         end
      end
   end

   assign outstanding_o = r_out;
   assign idle_o        = w_empty && (r_out == '0);
   assign error_o       = r_err;

`ifdef ACCEL_REQ_BUF_PERF_EN
   logic [31:0] r_perf_issued, r_perf_stall;
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_perf_issued <= '0;
         r_perf_stall  <= '0;
      end else begin
         r_perf_issued <= r_perf_issued + 32'(w_pop);
         r_perf_stall  <= r_perf_stall + 32'(w_valid && !acc_resp_i.req_ready);
      end
   end
   assign perf_issued_o = r_perf_issued;
   assign perf_stall_o  = r_perf_stall;
`else
   assign perf_issued_o = '0;
   assign perf_stall_o  = '0;
`endif
endmodule

// File: tb/tb_accel_req_buffer.sv
// tb_accel_req_buffer: directed plus random checks of accel_req_buffer against a queue-based reference model.
module tb_accel_req_buffer;
   import accel_req_buffer_pkg::*;
   localparam int DEPTH = 4;
   localparam int MAXO  = 2;
   localparam int OW    = $clog2(MAXO + 1);
`ifdef ACCEL_REQ_BUF_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   accelerator_req_t  req_i, req_o;
   accelerator_resp_t resp_i, resp_o;
   logic [OW-1:0]     outstanding;
   logic              idle, err;
   logic [31:0]       p_iss, p_stall;

   always #5 clk = ~clk;

   accel_req_buffer #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
      .clk_i(clk), .rst_i(rst),
      .acc_req_i(req_i), .acc_resp_o(resp_o),
      .acc_req_o(req_o), .acc_resp_i(resp_i),
      .outstanding_o(outstanding), .idle_o(idle), .error_o(err),
      .perf_issued_o(p_iss), .perf_stall_o(p_stall)
   );

   int               ntests = 0, nfail = 0;
   accelerator_req_t q[$];
   int               m_out = 0;
   bit               m_err = 1'b0;
   int unsigned      m_iss = 0, m_stall = 0;

   task automatic chk(string tag, logic [255:0] obs, logic [255:0] exp);
      ntests++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic accelerator_req_t rnd_req();
      accelerator_req_t r;
      r.req_valid  = 1'b1;
      r.resp_ready = 1'($urandom);
      r.insn       = $urandom;
      r.rs1        = {$urandom, $urandom};
      r.rs2        = {$urandom, $urandom};
      r.frm        = 3'($urandom);
      return r;
   endfunction

   task automatic drive(bit v, accelerator_req_t p, bit ar, bit rv, bit rr);
      req_i             = p;
      req_i.req_valid   = v;
      req_i.resp_ready  = rr;
      resp_i.req_ready  = ar;
      resp_i.resp_valid = rv;
      resp_i.result     = {$urandom, $urandom};
      resp_i.error      = 1'($urandom);
   endtask

   // check outputs against the model, then advance one clock and update the model
   task automatic step();
      bit ev, er, iss, push, rsp;
      accelerator_resp_t xr;
      accelerator_req_t p;
      #1;
      er = !rst && q.size() < DEPTH;
      ev = !rst && q.size() > 0 && m_out < MAXO;
      chk("req_ready", resp_o.req_ready, er);
      chk("req_valid", req_o.req_valid, ev);
      xr = resp_i;
      xr.req_ready = er;
      chk("resp_pass", resp_o, xr);
      chk("resp_ready_pass", req_o.resp_ready, req_i.resp_ready);
      if (!rst) begin
         chk("outstanding", outstanding, m_out);
         chk("idle", idle, q.size() == 0 && m_out == 0);
         chk("error", err, m_err);
         chk("perf_issued", p_iss, PERF ? m_iss : 0);
         chk("perf_stall", p_stall, PERF ? m_stall : 0);
         if (ev) chk("head", {req_o.insn, req_o.rs1, req_o.rs2, req_o.frm},
                     {q[0].insn, q[0].rs1, q[0].rs2, q[0].frm});
      end
      push = er && req_i.req_valid;
      iss  = ev && resp_i.req_ready;
      rsp  = resp_i.resp_valid && req_i.resp_ready;
      p = req_i;
      p.req_valid = 1'b0;
      p.resp_ready = 1'b0;
      @(posedge clk);
      if (rst) begin
         q.delete();
         m_out = 0; m_err = 1'b0; m_iss = 0; m_stall = 0;
      end else begin
         if (iss) begin void'(q.pop_front()); m_iss++; end
         if (ev && !resp_i.req_ready) m_stall++;
         if (push) q.push_back(p);
         if (iss && !rsp) m_out++;
         else if (rsp && !iss) begin
            if (m_out == 0) m_err = 1'b1;
            else m_out--;
         end
      end
      @(negedge clk);
   endtask

   initial begin
      accelerator_req_t r;
      r = rnd_req();
      drive(0, r, 1, 0, 1);
      @(negedge clk);
      step();
      rst = 1'b0;
      // single push, issued the cycle after being stored
      r = rnd_req();
      r.insn = 32'h0200_7057;
      drive(1, r, 1, 0, 1);
      step();
      drive(0, r, 1, 0, 1);
      #1;
      chk("t1_valid", req_o.req_valid, 1);
      chk("t1_insn", req_o.insn, 32'h0200_7057);
      chk("t1_rs1", req_o.rs1, r.rs1);
      step();
      #1;
      chk("t1_outstanding", outstanding, 1);
      // Ara stalls, five pushes into a four-entry FIFO
      for (int i = 0; i < 5; i++) begin
         drive(1, rnd_req(), 0, 0, 1);
         step();
      end
      drive(0, rnd_req(), 0, 0, 1);
      #1;
      chk("t2_full", resp_o.req_ready, 0);
      chk("t2_depth", q.size(), DEPTH);
      // limiter at MAX_OUTSTANDING
      for (int i = 0; i < 3; i++) begin
         drive(0, rnd_req(), 1, 0, 1);
         step();
      end
      #1;
      chk("t3_blocked", req_o.req_valid, 0);
      chk("t3_outstanding", outstanding, 2);
      drive(0, rnd_req(), 1, 1, 1);
      step();
      #1;
      chk("t3_reissue", req_o.req_valid, 1);
      drive(0, rnd_req(), 1, 1, 1);
      step();
      #1;
      chk("t4_same_cycle", outstanding, 1);
      // drain, then a response with nothing outstanding
      for (int i = 0; i < 20 && (q.size() != 0 || m_out != 0); i++) begin
         drive(0, rnd_req(), 1, 1, 1);
         step();
      end
      #1;
      chk("t5_idle", idle, 1);
      chk("t5_err_clear", err, 0);
      drive(0, rnd_req(), 1, 1, 1);
      step();
      #1;
      chk("t5_err_set", err, 1);
      chk("t5_out_zero", outstanding, 0);
      for (int i = 0; i < 3; i++) begin
         drive(0, rnd_req(), 1, 0, 1);
         step();
      end
      #1;
      chk("t5_err_sticky", err, 1);
      // reset mid-stream discards buffered entries
      for (int i = 0; i < 3; i++) begin
         drive(1, rnd_req(), 0, 0, 1);
         step();
      end
      rst = 1'b1;
      drive(1, rnd_req(), 1, 0, 1);
      step();
      rst = 1'b0;
      drive(0, rnd_req(), 1, 0, 1);
      #1;
      chk("t6_idle", idle, 1);
      chk("t6_valid", req_o.req_valid, 0);
      chk("t6_err", err, 0);
      // pointer wrap with in-order delivery
      for (int i = 0; i < 2 * DEPTH; i++) begin
         drive(1, rnd_req(), 1, 1, 1);
         step();
      end
      for (int i = 0; i < 20 && (q.size() != 0 || m_out != 0); i++) begin
         drive(0, rnd_req(), 1, 1, 1);
         step();
      end
      #1;
      chk("t7_drained", idle, 1);
      // random traffic with occasional reset
      for (int i = 0; i < 800; i++) begin
         drive($urandom_range(0, 3) != 0, rnd_req(), $urandom_range(0, 3) != 0,
               $urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0);
         rst = $urandom_range(0, 99) == 0;
         step();
      end
      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end
endmodule
